// File: rtl/multicycle_controller_if.sv
// Instruction and data memory request/ready handshakes
// between the multicycle controller and the memories.
interface multicycle_controller_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: fetch, decode, exec, mem, write-back.
// Optional perf counters: MULTICYCLE_CTRL_PERF_CNT_EN.
module multicycle_controller #(
  parameter int STATE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ins_ADD,
  input  logic               ins_SUB,
  input  logic               ins_LW,
  input  logic               ins_SW,
  input  logic               ins_ADDI,
  input  logic               ins_LUI,
  input  logic               ins_JAL,
  input  logic [4:0]         reg_rd,
  multicycle_controller_if.master mem,
  output logic               ir_we,
  output logic               pc_we,
  output logic               pc_sel,
  output logic               reg_we,
  output logic [1:0]         alu_op,
  output logic               alu_b_sel,
  output logic [1:0]         wb_sel,
  output logic               illegal,
  output logic [STATE_W-1:0] state,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instret_cnt
);

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = STATE_W'(0),
    S_FETCH  = STATE_W'(1),
    S_DECODE = STATE_W'(2),
    S_EXEC   = STATE_W'(3),
    S_MEM    = STATE_W'(4),
    S_WB     = STATE_W'(5),
    S_HALT   = STATE_W'(6)
  } state_t;

  typedef enum logic [2:0] {
    C_ADD  = 3'd0,
    C_SUB  = 3'd1,
    C_LW   = 3'd2,
    C_SW   = 3'd3,
    C_ADDI = 3'd4,
    C_LUI  = 3'd5,
    C_JAL  = 3'd6
  } cls_t;

  state_t state_q;
  state_t state_d;
  cls_t   cls_q;
  cls_t   cls_d;

  logic [6:0] stb;
  logic       stb_ok;

  logic imem_req;
  logic dmem_req;
  logic dmem_we;

  logic is_lw;
  logic is_sw;
  logic is_jal;

  assign stb = {ins_JAL, ins_LUI, ins_ADDI,
                ins_SW, ins_LW, ins_SUB, ins_ADD};

  // Exactly one strobe: non-zero and no second bit set.
  assign stb_ok = (stb != 7'd0) &&
                  ((stb & (stb - 7'd1)) == 7'd0);

  always_comb begin
    cls_d = C_ADD;
    if (stb_ok) begin
      unique case (1'b1)
        ins_ADD:  cls_d = C_ADD;
        ins_SUB:  cls_d = C_SUB;
        ins_LW:   cls_d = C_LW;
        ins_SW:   cls_d = C_SW;
        ins_ADDI: cls_d = C_ADDI;
        ins_LUI:  cls_d = C_LUI;
        ins_JAL:  cls_d = C_JAL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= C_ADD;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        cls_q <= cls_d;
      end
    end
  end

  assign is_lw  = (cls_q == C_LW);
  assign is_sw  = (cls_q == C_SW);
  assign is_jal = (cls_q == C_JAL);

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    reg_we    = 1'b0;
    alu_op    = 2'b00;
    alu_b_sel = 1'b0;
    wb_sel    = 2'b00;
    illegal   = 1'b0;

    // ALU controls are held from EXEC through MEM and WB.
    if (state_q == S_EXEC ||
        state_q == S_MEM ||
        state_q == S_WB) begin
      alu_b_sel = is_lw | is_sw |
                  (cls_q == C_ADDI) |
                  (cls_q == C_LUI);
      if (cls_q == C_LUI) begin
        alu_op = 2'b10;
      end else if (cls_q == C_SUB) begin
        alu_op = 2'b01;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (mem.imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = stb_ok ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        state_d = (is_lw | is_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (mem.dmem_ready) begin
          if (is_sw) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        pc_we   = 1'b1;
        pc_sel  = is_jal;
        reg_we  = (reg_rd != 5'd0);
        state_d = S_FETCH;
        if (is_lw) begin
          wb_sel = 2'b01;
        end else if (is_jal) begin
          wb_sel = 2'b10;
        end
      end
      S_HALT: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem.imem_req = imem_req;
  assign mem.dmem_req = dmem_req;
  assign mem.dmem_we  = dmem_we;
  assign state        = state_q;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [31:0] cyc_q;
  logic [31:0] ret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= 32'd0;
      ret_q <= 32'd0;
    end else begin
      if (state_q != S_IDLE &&
          state_q != S_HALT) begin
        cyc_q <= cyc_q + 32'd1;
      end
      if (pc_we) begin
        ret_q <= ret_q + 32'd1;
      end
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected
// output vectors are queued with their stimulus and compared in order.
module tb_multicycle_controller;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  localparam int K_ADD  = 0;
  localparam int K_SUB  = 1;
  localparam int K_LW   = 2;
  localparam int K_SW   = 3;
  localparam int K_ADDI = 4;
  localparam int K_LUI  = 5;
  localparam int K_JAL  = 6;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic        imr;
    logic        dmr;
    logic [6:0]  stb;
    logic [4:0]  rd;
    logic [15:0] exp;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  stb = 7'd0;
  logic [4:0]  rd  = 5'd0;
  logic        ir_we;
  logic        pc_we;
  logic        pc_sel;
  logic        reg_we;
  logic [1:0]  alu_op;
  logic        alu_b_sel;
  logic [1:0]  wb_sel;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
  logic [15:0] obs;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_cyc = 32'd0;
  logic [31:0] m_ret = 32'd0;
  cyc_t        sbq[$];
  cyc_t        c;

  multicycle_controller_if bus ();

  multicycle_controller #(.STATE_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .ins_ADD     (stb[0]),
    .ins_SUB     (stb[1]),
    .ins_LW      (stb[2]),
    .ins_SW      (stb[3]),
    .ins_ADDI    (stb[4]),
    .ins_LUI     (stb[5]),
    .ins_JAL     (stb[6]),
    .reg_rd      (rd),
    .mem         (bus),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .reg_we      (reg_we),
    .alu_op      (alu_op),
    .alu_b_sel   (alu_b_sel),
    .wb_sel      (wb_sel),
    .illegal     (illegal),
    .state       (state),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  // flags = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we}
  assign obs = {state, bus.imem_req, bus.dmem_req, bus.dmem_we,
                ir_we, pc_we, pc_sel, reg_we,
                alu_op, alu_b_sel, wb_sel, illegal};

  function automatic logic [15:0] mk(
    input logic [2:0] st, input logic [6:0] fl,
    input logic [1:0] op, input logic bs,
    input logic [1:0] wb, input logic il);
    return {st, fl, op, bs, wb, il};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] rs();
    return 7'($urandom);
  endfunction

  function automatic void put(
    input logic imr, input logic dmr, input logic [6:0] s,
    input logic [4:0] r, input logic [15:0] e);
    cyc_t x;
    x.imr = imr;
    x.dmr = dmr;
    x.stb = s;
    x.rd  = r;
    x.exp = e;
    sbq.push_back(x);
  endfunction

  function automatic void push_instr(
    input int k, input logic [4:0] r, input int iw, input int dw);
    logic [6:0] s;
    logic       ld, st, jl, bs, rw;
    logic [1:0] op, wb;
    s  = 7'(1 << k);
    ld = (k == K_LW);
    st = (k == K_SW);
    jl = (k == K_JAL);
    bs = ld | st | (k == K_ADDI) | (k == K_LUI);
    op = (k == K_LUI) ? 2'b10 : (k == K_SUB) ? 2'b01 : 2'b00;
    wb = ld ? 2'b01 : jl ? 2'b10 : 2'b00;
    rw = (r != 5'd0);
    for (int i = 0; i < iw; i++)
      put(1'b0, rb(), rs(), r,
          mk(ST_FETCH, 7'b1000000, 2'b00, 1'b0, 2'b00, 1'b0));
    put(1'b1, rb(), rs(), r,
        mk(ST_FETCH, 7'b1001000, 2'b00, 1'b0, 2'b00, 1'b0));
    put(rb(), rb(), s, r,
        mk(ST_DECODE, 7'b0, 2'b00, 1'b0, 2'b00, 1'b0));
    put(rb(), rb(), rs(), r,
        mk(ST_EXEC, 7'b0, op, bs, 2'b00, 1'b0));
    if (ld | st) begin
      for (int i = 0; i < dw; i++)
        put(rb(), 1'b0, rs(), r,
            mk(ST_MEM, {2'b01, st, 4'b0000}, op, bs, 2'b00, 1'b0));
      put(rb(), 1'b1, rs(), r,
          mk(ST_MEM, {2'b01, st, 1'b0, st, 2'b00}, op, bs, 2'b00, 1'b0));
    end
    if (!st)
      put(rb(), rb(), rs(), r,
          mk(ST_WB, {4'b0000, 1'b1, jl, rw}, op, bs, wb, 1'b0));
  endfunction

  function automatic void push_bad(input logic [6:0] s, input int nh);
    put(1'b1, rb(), rs(), 5'd7,
        mk(ST_FETCH, 7'b1001000, 2'b00, 1'b0, 2'b00, 1'b0));
    put(rb(), rb(), s, 5'd7,
        mk(ST_DECODE, 7'b0, 2'b00, 1'b0, 2'b00, 1'b0));
    for (int i = 0; i < nh; i++)
      put(rb(), rb(), rs(), 5'd7,
          mk(ST_HALT, 7'b0, 2'b00, 1'b0, 2'b00, 1'b1));
  endfunction

  task automatic apply(input cyc_t x);
    bus.imem_ready = x.imr;
    bus.dmem_ready = x.dmr;
    stb            = x.stb;
    rd             = x.rd;
  endtask

  function automatic void account(input logic [15:0] e);
    if (e[15:13] != ST_IDLE && e[15:13] != ST_HALT)
      m_cyc = m_cyc + 32'd1;
    if (e[8])
      m_ret = m_ret + 32'd1;
  endfunction

  task automatic test_reset();
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    stb = 7'h7f;
    rd  = 5'd3;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (obs !== 16'h0) begin
      n_err++;
      $display("FAIL reset_out: got %h expected 0000", obs);
    end
    n_chk++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d %0d expected 0 0",
               cycle_cnt, instret_cnt);
    end
    rst = 1'b0;
    m_cyc = 32'd0;
    m_ret = 32'd0;
    put(rb(), rb(), rs(), 5'd3, 16'h0);
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      apply(c);
      @(negedge clk);
      n_chk++;
      if (obs !== c.exp) begin
        n_err++;
        $display("FAIL reset_idle: got %h expected %h", obs, c.exp);
      end
      account(c.exp);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_add();
    push_instr(K_ADD, 5'd5, 0, 0);
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      apply(c);
      @(negedge clk);
      n_chk++;
      if (obs !== c.exp) begin
        n_err++;
        $display("FAIL add: got %h expected %h", obs, c.exp);
      end
      account(c.exp);
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (cycle_cnt !== (PERF ? m_cyc : 32'd0) ||
        instret_cnt !== (PERF ? m_ret : 32'd0)) begin
      n_err++;
      $display("FAIL add_cnt: got %0d %0d expected %0d %0d",
               cycle_cnt, instret_cnt, m_cyc, m_ret);
    end
  endtask

  task automatic test_lw_wait();
    push_instr(K_LW, 5'd12, 0, 3);
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      apply(c);
      @(negedge clk);
      n_chk++;
      if (obs !== c.exp) begin
        n_err++;
        $display("FAIL lw_wait: got %h expected %h", obs, c.exp);
      end
      account(c.exp);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_sw_jal();
    push_instr(K_SW, 5'd4, 1, 0);
    push_instr(K_JAL, 5'd1, 0, 0);
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      apply(c);
      @(negedge clk);
      n_chk++;
      if (obs !== c.exp) begin
        n_err++;
        $display("FAIL sw_jal: got %h expected %h", obs, c.exp);
      end
      account(c.exp);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_addi_x0();
    push_instr(K_ADDI, 5'd0, 0, 0);
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      apply(c);
      @(negedge clk);
      n_chk++;
      if (obs !== c.exp) begin
        n_err++;
        $display("FAIL addi_x0: got %h expected %h", obs, c.exp);
      end
      account(c.exp);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++)
      push_instr($urandom_range(0, 6), 5'($urandom),
                 $urandom_range(0, 2), $urandom_range(0, 2));
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      apply(c);
      @(negedge clk);
      n_chk++;
      if (obs !== c.exp) begin
        n_err++;
        $display("FAIL b2b: got %h expected %h", obs, c.exp);
      end
      account(c.exp);
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (cycle_cnt !== (PERF ? m_cyc : 32'd0) ||
        instret_cnt !== (PERF ? m_ret : 32'd0)) begin
      n_err++;
      $display("FAIL b2b_cnt: got %0d %0d expected %0d %0d",
               cycle_cnt, instret_cnt, m_cyc, m_ret);
    end
  endtask

  task automatic test_halt();
    for (int p = 0; p < 2; p++) begin
      push_bad((p == 0) ? 7'h00 : 7'h24, (p == 0) ? 20 : 3);
      while (sbq.size() > 0) begin
        c = sbq.pop_front();
        apply(c);
        @(negedge clk);
        n_chk++;
        if (obs !== c.exp) begin
          n_err++;
          $display("FAIL halt%0d: got %h expected %h", p, obs, c.exp);
        end
        account(c.exp);
        @(posedge clk);
        #1;
      end
      n_chk++;
      if (cycle_cnt !== (PERF ? m_cyc : 32'd0)) begin
        n_err++;
        $display("FAIL halt_cnt%0d: got %0d expected %0d",
                 p, cycle_cnt, m_cyc);
      end
      #2;
      rst = 1'b1;
      #1;
      n_chk++;
      if (obs !== 16'h0) begin
        n_err++;
        $display("FAIL halt_rst%0d: got %h expected 0000", p, obs);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_cyc = 32'd0;
      m_ret = 32'd0;
      put(rb(), rb(), rs(), 5'd2, 16'h0);
      while (sbq.size() > 0) begin
        c = sbq.pop_front();
        apply(c);
        @(negedge clk);
        n_chk++;
        if (obs !== c.exp) begin
          n_err++;
          $display("FAIL halt_idle%0d: got %h expected %h",
                   p, obs, c.exp);
        end
        account(c.exp);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_rst_mem();
    push_instr(K_ADD, 5'd6, 0, 0);
    push_instr(K_SW, 5'd9, 0, 10);
    for (int k = 0; k < 10; k++) begin
      c = sbq.pop_front();
      apply(c);
      @(negedge clk);
      n_chk++;
      if (obs !== c.exp) begin
        n_err++;
        $display("FAIL rst_mem_pre: got %h expected %h", obs, c.exp);
      end
      account(c.exp);
      @(posedge clk);
      #1;
    end
    sbq.delete();
    bus.dmem_ready = 1'b0;
    #2;
    n_chk++;
    if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mem_wait: got req %b we %b expected 1 1",
               bus.dmem_req, bus.dmem_we);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 ||
        obs !== 16'h0) begin
      n_err++;
      $display("FAIL rst_mem_drop: got req %b we %b out %h expected 0",
               bus.dmem_req, bus.dmem_we, obs);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cyc = 32'd0;
    m_ret = 32'd0;
    n_chk++;
    if (instret_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL rst_mem_cnt0: got %0d %0d expected 0 0",
               cycle_cnt, instret_cnt);
    end
    put(rb(), rb(), rs(), 5'd3, 16'h0);
    push_instr(K_ADD, 5'd3, 0, 0);
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      apply(c);
      @(negedge clk);
      n_chk++;
      if (obs !== c.exp) begin
        n_err++;
        $display("FAIL rst_mem_post: got %h expected %h", obs, c.exp);
      end
      account(c.exp);
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (instret_cnt !== (PERF ? 32'd1 : 32'd0) ||
        cycle_cnt !== (PERF ? m_cyc : 32'd0)) begin
      n_err++;
      $display("FAIL rst_mem_cnt1: got %0d %0d expected %0d %0d",
               cycle_cnt, instret_cnt, m_cyc, m_ret);
    end
  endtask

  initial begin
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_sw_jal();
    test_addi_x0();
    test_back_to_back();
    test_halt();
    test_rst_mem();
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
